multi_digit_bcd_counter: RTL and testbench

MULTI_DIGIT_BCD_COUNTER -- requirements
Module: multi_digit_bcd_counter

---
 rtl/multi_digit_bcd_counter.sv | 98 +++++++++
 tb/tb_multi_digit_bcd_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multi_digit_bcd_counter.sv
// Cascaded modulo-MOD up/down counter with parallel load.
// Each 4-bit digit counts 0..MOD-1. A digit moves only when every lower digit
// sits at its extreme: MOD-1 when counting up, 0 when counting down.
// tc is the combinational ripple-carry for chaining instances. wrapped and
// load_err are registered one-cycle status pulses.
module multi_digit_bcd_counter #(
  parameter int DIGITS = 2,  // number of cascaded digits, 1..8
  parameter int MOD    = 10  // modulus of every digit, 2..16
) (
  input  logic                  x,        // clock
  input  logic                  reset,    // synchronous, active high
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   z,
  output logic                  tc,
  output logic                  wrapped,
  output logic                  load_err
);

  localparam logic [3:0] MAX_DIGIT = 4'(MOD - 1);
  // Five bits so that MOD = 16 is representable in the load range check.
  localparam logic [4:0] MOD_W     = 5'(MOD);

  logic [4*DIGITS-1:0] z_q, z_d;
  logic                wrapped_q, wrapped_d;
  logic                load_err_q, load_err_d;

  // lower_max[i] / lower_zero[i]: every digit below digit i is at MOD-1 / 0.
  // Index DIGITS therefore covers the whole count.
  logic [DIGITS:0]     lower_max;
  logic [DIGITS:0]     lower_zero;

  // Prefix flags along the digit chain.
  always_comb begin
    lower_max[0]  = 1'b1;
    lower_zero[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lower_max[i+1]  = lower_max[i]  & (z_q[4*i +: 4] == MAX_DIGIT);
      lower_zero[i+1] = lower_zero[i] & (z_q[4*i +: 4] == 4'd0);
    end
  end

  // Next-state logic. Load takes priority over counting.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that left
    // one unassigned would infer a latch.
    z_d        = z_q;
    wrapped_d  = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      // Digits outside 0..MOD-1 load as 0 and raise load_err. A load never
      // reports a wrap.
      for (int i = 0; i < DIGITS; i++) begin
        if ({1'b0, d[4*i +: 4]} >= MOD_W) begin
          z_d[4*i +: 4] = 4'd0;
          load_err_d    = 1'b1;
        end else begin
          z_d[4*i +: 4] = d[4*i +: 4];
        end
      end
    end else if (en) begin
      wrapped_d = up ? lower_max[DIGITS] : lower_zero[DIGITS];
      for (int i = 0; i < DIGITS; i++) begin
        if (up && lower_max[i]) begin
          z_d[4*i +: 4] = (z_q[4*i +: 4] == MAX_DIGIT) ? 4'd0
                                                       : z_q[4*i +: 4] + 4'd1;
        end else if (!up && lower_zero[i]) begin
          z_d[4*i +: 4] = (z_q[4*i +: 4] == 4'd0) ? MAX_DIGIT
                                                  : z_q[4*i +: 4] - 4'd1;
        end
      end
    end
  end

  // State registers. Reset overrides load, en and up.
  always_ff @(posedge x) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values and no update order exists between them.
    if (reset) begin
      z_q        <= '0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      z_q        <= z_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  assign z        = z_q;
  assign wrapped  = wrapped_q;
  assign load_err = load_err_q;
  // Combinational ripple-carry, with zero latency from en and up.
  assign tc       = en & (up ? lower_max[DIGITS] : lower_zero[DIGITS]);

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Self-checking bench for multi_digit_bcd_counter.
// Two instances share one stimulus stream:
//   u_a: DIGITS = 2, MOD = 10
//   u_b: DIGITS = 1, MOD = 6
// The reference model holds each count as a plain integer modulo MOD**DIGITS
// and converts it to and from digit fields.
module tb_multi_digit_bcd_counter;

  localparam int DIG_A = 2, MOD_A = 10, FULL_A = 100;
  localparam int DIG_B = 1, MOD_B = 6,  FULL_B = 6;

  logic       x = 1'b0;
  logic       reset, en, up, load;
  logic [7:0] d_a, z_a;
  logic [3:0] d_b, z_b;
  logic       tc_a, wrapped_a, load_err_a;
  logic       tc_b, wrapped_b, load_err_b;

  int vectors    = 0;
  int miscompares = 0;

  // Model state for each instance.
  int cnt_a = 0, cnt_b = 0;
  bit w_a = 0, le_a = 0, w_b = 0, le_b = 0;
  bit model_valid = 0;

  always #5 x = ~x;

  multi_digit_bcd_counter #(.DIGITS(DIG_A), .MOD(MOD_A)) u_a (
    .x(x), .reset(reset), .en(en), .up(up), .load(load), .d(d_a),
    .z(z_a), .tc(tc_a), .wrapped(wrapped_a), .load_err(load_err_a)
  );

  multi_digit_bcd_counter #(.DIGITS(DIG_B), .MOD(MOD_B)) u_b (
    .x(x), .reset(reset), .en(en), .up(up), .load(load), .d(d_b),
    .z(z_b), .tc(tc_b), .wrapped(wrapped_b), .load_err(load_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Integer count -> packed digit fields, least significant digit first.
  function automatic logic [31:0] to_z(input int val, input int digs,
                                       input int m);
    logic [31:0] r = '0;
    int v = val;
    for (int i = 0; i < digs; i++) begin
      r[4*i +: 4] = 4'(v % m);
      v = v / m;
    end
    return r;
  endfunction

  // Packed load value -> integer count. Digits >= m count as 0 and set err.
  function automatic int from_d(input logic [31:0] dv, input int digs,
                                input int m, output bit err);
    int v = 0;
    err = 0;
    for (int i = digs - 1; i >= 0; i--) begin
      int dig = int'(dv[4*i +: 4]);
      if (dig >= m) begin
        err = 1;
        dig = 0;
      end
      v = v * m + dig;
    end
    return v;
  endfunction

  // Next model state for one edge: reset > load > en > hold.
  task automatic model_edge(input bit r, l, e, u, input logic [31:0] dv,
                            input int digs, m, full,
                            inout int cnt, inout bit w, inout bit le);
    bit err;
    if (r) begin
      cnt = 0; w = 0; le = 0;
    end else if (l) begin
      cnt = from_d(dv, digs, m, err);
      w = 0; le = err;
    end else if (e) begin
      w   = u ? (cnt == full - 1) : (cnt == 0);
      cnt = u ? (cnt + 1) % full : (cnt + full - 1) % full;
      le  = 0;
    end else begin
      w = 0; le = 0;
    end
  endtask

  // Apply inputs and check tc before the edge. Clock one edge, then check
  // the registered outputs.
  task automatic step(input bit r, l, e, u, input logic [7:0] dv);
    reset = r; load = l; en = e; up = u;
    d_a = dv; d_b = dv[3:0];
    #1;
    if (model_valid) begin
      check("tc_a", 32'(tc_a), 32'(e && (u ? cnt_a == FULL_A - 1 : cnt_a == 0)));
      check("tc_b", 32'(tc_b), 32'(e && (u ? cnt_b == FULL_B - 1 : cnt_b == 0)));
    end
    @(posedge x);
    model_edge(r, l, e, u, 32'(dv), DIG_A, MOD_A, FULL_A, cnt_a, w_a, le_a);
    model_edge(r, l, e, u, 32'(dv), DIG_B, MOD_B, FULL_B, cnt_b, w_b, le_b);
    if (r) model_valid = 1;
    #1;
    if (model_valid) begin
      check("z_a",        32'(z_a),        to_z(cnt_a, DIG_A, MOD_A));
      check("wrapped_a",  32'(wrapped_a),  32'(w_a));
      check("load_err_a", 32'(load_err_a), 32'(le_a));
      check("z_b",        32'(z_b),        to_z(cnt_b, DIG_B, MOD_B));
      check("wrapped_b",  32'(wrapped_b),  32'(w_b));
      check("load_err_b", 32'(load_err_b), 32'(le_b));
    end
  endtask

  initial begin
    logic [7:0] dr;
    reset = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d_a = '0; d_b = '0;

    // Reset held for several edges, with other controls active.
    step(1, 0, 0, 0, 8'h00);
    step(1, 1, 1, 1, 8'h55);
    step(1, 0, 1, 0, 8'h00);

    // Up count for 100 edges: 00..99, then back to 00.
    for (int i = 0; i < 100; i++) step(0, 0, 1, 1, 8'h00);

    // Down count from 00 wraps to 99, then steps to 98.
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);

    // Load with en asserted, then hold for 5 edges.
    step(0, 1, 1, 1, 8'h47);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'h00);

    // Loads containing out-of-range digits.
    step(0, 1, 0, 0, 8'h5C);
    step(0, 1, 0, 0, 8'hF3);

    // Count up to 63, then assert reset together with load and en.
    step(0, 1, 0, 0, 8'h60);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'h00);
    step(1, 1, 1, 1, 8'h99);

    // Direction change while counting, around the zero boundary.
    step(0, 0, 1, 1, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 1, 8'h00);

    // Randomized traffic, with loads biased toward the wrap boundaries.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       dr = 8'h99;
        1:       dr = 8'h00;
        2:       dr = 8'h05;
        default: dr = 8'($urandom);
      endcase
      step($urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom), dr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
